// File: rtl/arith_pkg.sv
// arith_pkg
//   Definitions shared by the bit-serial arithmetic blocks: the FSM state
//   encoding used by the serial controllers and the default operand width.
//   Optional feature macro used by importers: SERIAL_SUB_OVF_EN.
package arith_pkg;

  // Default operand/result width for the serial arithmetic blocks.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states: wait for a launch, shift one bit per clock, present result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   One-bit combinational full-subtractor cell: computes inA - inB - Bin.
//   Ports:
//     inA  in  1  minuend bit
//     inB  in  1  subtrahend bit
//     Bin  in  1  borrow in from the less significant bit
//     outD out 1  difference bit
//     Bout out 1  borrow out to the next more significant bit
module full_subtractor (
  input  logic inA,
  input  logic inB,
  input  logic Bin,
  output logic outD,
  output logic Bout
);

  assign outD = inA ^ inB ^ Bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow arrives.
  assign Bout = (~inA & inB) | (~(inA ^ inB) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: outD = inA - inB, one bit per clock,
//   LSB first, through a single full_subtractor cell and a borrow register.
//   A start/busy/done handshake launches one operation and presents its result.
//   Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output outV.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous active-high reset
//     start  in   1      launch request, sampled only in IDLE
//     inA    in   WIDTH  minuend, captured on the accepting edge
//     inB    in   WIDTH  subtrahend, captured on the accepting edge
//     busy   out  1      high while shifting
//     done   out  1      one-cycle result-valid pulse
//     outD   out  WIDTH  difference mod 2^WIDTH
//     Bout   out  1      final borrow (unsigned inA < inB)
//     outV   out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outD,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             outV
`endif
);

  // One extra counter bit so the count can step past WIDTH-1 without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;

  logic cell_d;
  logic cell_bout;

  full_subtractor u_cell (
    .inA  (a_q[0]),
    .inB  (b_q[0]),
    .Bin  (borrow_q),
    .outD (cell_d),
    .Bout (cell_bout)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // The result register is left alone here so the previous result
            // stays visible until shifting starts overwriting it.
            a_q      <= inA;
            b_q      <= inB;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end

        SHIFT: begin
          res_q    <= {cell_d, res_q[WIDTH-1:1]};
          borrow_q <= cell_bout;
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_SUB_OVF_EN
            // Overflow is only possible when the operand signs differ and the
            // result sign disagrees with the minuend sign.
            ovf_q <= (a_q[0] ^ b_q[0]) & (a_q[0] ^ cell_d);
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign outD = res_q;
  assign Bout = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign outV = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Drives a WIDTH=8 and a WIDTH=13 serial_subtractor side by side and checks
//   each result against plain integer subtraction.
//   Optional feature macro: SERIAL_SUB_OVF_EN (enables outV checks).
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  inA8 = '0, inB8 = '0;
  logic [12:0] inA13 = '0, inB13 = '0;
  logic        busy8, done8, Bout8, busy13, done13, Bout13;
  logic [7:0]  outD8;
  logic [12:0] outD13;
`ifdef SERIAL_SUB_OVF_EN
  logic        outV8, outV13;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .inA(inA8), .inB(inB8),
    .busy(busy8), .done(done8), .outD(outD8), .Bout(Bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .outV(outV8)
`endif
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start), .inA(inA13), .inB(inB13),
    .busy(busy13), .done(done13), .outD(outD13), .Bout(Bout13)
`ifdef SERIAL_SUB_OVF_EN
    , .outV(outV13)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unsigned difference mod 2^w, borrow = unsigned a<b,
  // overflow = true signed difference outside the w-bit signed range.
  function automatic logic ovf_ref(input int a, input int b, input int w);
    int sa, sb, r;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    r  = sa - sb;
    return (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endfunction

  // One operation on both instances. inj>0 pulses a second start (with other
  // operands) at that cycle of the operation; it must be ignored.
  task automatic run_op(input logic [7:0] a8, input logic [7:0] b8,
                        input logic [12:0] a13, input logic [12:0] b13, input int inj);
    int pulses8, pulses13;
    logic [31:0] exp_d8, exp_d13;
    exp_d8  = 32'((int'(a8) - int'(b8) + 256) % 256);
    exp_d13 = 32'((int'(a13) - int'(b13) + 8192) % 8192);
    pulses8 = 0;
    pulses13 = 0;
    inA8 = a8; inB8 = b8; inA13 = a13; inB13 = b13;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy8_after_accept", 32'(busy8), 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (inj != 0 && k == inj) begin
        start = 1'b1; inA8 = 8'hFF; inB8 = 8'h00; inA13 = 13'h1FFF; inB13 = 13'h0;
      end else begin
        start = 1'b0;
      end
      if (done8) begin
        pulses8++;
        chk("latency8", 32'(k), 32'd8);
        chk("outD8", 32'(outD8), exp_d8);
        chk("Bout8", 32'(Bout8), 32'(a8 < b8));
`ifdef SERIAL_SUB_OVF_EN
        chk("outV8", 32'(outV8), 32'(ovf_ref(int'(a8), int'(b8), 8)));
`endif
      end
      if (done13) begin
        pulses13++;
        chk("latency13", 32'(k), 32'd13);
        chk("outD13", 32'(outD13), exp_d13);
        chk("Bout13", 32'(Bout13), 32'(a13 < b13));
`ifdef SERIAL_SUB_OVF_EN
        chk("outV13", 32'(outV13), 32'(ovf_ref(int'(a13), int'(b13), 13)));
`endif
      end
    end
    start = 1'b0;
    chk("done8_pulses", 32'(pulses8), 32'd1);
    chk("done13_pulses", 32'(pulses13), 32'd1);
    chk("outD8_hold_idle", 32'(outD8), exp_d8);
    chk("busy13_idle", 32'(busy13), 32'd0);
    $display("op a8=%02h b8=%02h d8=%02h B8=%0d | a13=%04h b13=%04h d13=%04h B13=%0d",
             a8, b8, outD8, Bout8, a13, b13, outD13, Bout13);
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_outD", 32'(outD8), 32'd0);
    chk("rst_Bout", 32'(Bout8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op(8'h05, 8'h03, 13'h0005, 13'h0003, 0);
    run_op(8'h03, 8'h05, 13'h0003, 13'h0005, 0);
    run_op(8'h80, 8'h01, 13'h1000, 13'h0001, 0);
    run_op(8'h00, 8'h00, 13'h0000, 13'h0000, 0);
    run_op(8'h7F, 8'h80, 13'h0FFF, 13'h1000, 0);
    run_op(8'h10, 8'h01, 13'h0010, 13'h0001, 3);
    run_op(8'hFF, 8'hFF, 13'h1FFF, 13'h0000, 0);

    // Reset in the middle of an operation.
    inA8 = 8'h55; inB8 = 8'h0A; inA13 = 13'h0555; inB13 = 13'h000A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy8", 32'(busy8), 32'd0);
    chk("midrst_outD8", 32'(outD8), 32'd0);
    chk("midrst_Bout8", 32'(Bout8), 32'd0);
    chk("midrst_busy13", 32'(busy13), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done8 || done13) pulses++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);
    run_op(8'h40, 8'h41, 13'h0040, 13'h0041, 0);

    // Random operands.
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 13'($urandom), 13'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
